// File: rtl/wide_add_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : wide_add_sequencer
//  Description : Performs a 64-bit add with a single external 32-bit adder.
//                The low half goes through the adder first and the high half
//                second, with the carry between them registered. Each half is
//                held on the adder for SETTLE_CYCLES clocks before capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module wide_add_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        in_cin,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum,
    output logic        out_cout,
    output logic        out_ovf
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_lo   = 2'd1;
    localparam logic [1:0] c_hi   = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    // Counter value at which the current half's result is captured.
    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic        r_cin;
    logic        r_lo_cout;
    logic        w_settled;

    assign w_settled = (r_cnt == c_settle_last);

    // Requests are only taken while idle; no same-cycle turnaround from DONE.
    assign in_ready = (r_state == c_idle);

    // Sequencer: accept, settle/capture low half, settle/capture high half, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_cnt     <= 4'd0;
            r_a       <= 64'd0;
            r_b       <= 64'd0;
            r_cin     <= 1'b0;
            r_lo_cout <= 1'b0;
            out_sum   <= 64'd0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_cin   <= in_cin;
                        r_cnt   <= 4'd0;
                        r_state <= c_lo;
                    end
                end
                c_lo: begin
                    if (w_settled) begin
                        out_sum[31:0] <= add_sum;
                        r_lo_cout     <= add_cout;
                        r_cnt         <= 4'd0;
                        r_state       <= c_hi;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_hi: begin
                    if (w_settled) begin
                        out_sum[63:32] <= add_sum;
                        out_cout       <= add_cout;
                        // Same-sign operands producing an opposite-sign result.
                        out_ovf        <= (r_a[63] == r_b[63]) && (add_sum[31] != r_a[63]);
                        out_valid      <= 1'b1;
                        r_cnt          <= 4'd0;
                        r_state        <= c_done;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // Steer the selected operand half onto the external adder; quiet when not adding.
    always_comb begin
        add_a   = 32'd0;
        add_b   = 32'd0;
        add_cin = 1'b0;
        case (r_state)
            c_lo: begin
                add_a   = r_a[31:0];
                add_b   = r_b[31:0];
                add_cin = r_cin;
            end
            c_hi: begin
                add_a   = r_a[63:32];
                add_b   = r_b[63:32];
                add_cin = r_lo_cout;
            end
            default: begin
                add_a   = 32'd0;
                add_b   = 32'd0;
                add_cin = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/wide_add_sequencer.md
WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port SHALL be named clk and the reset port rst.
REQ-002 Parameter: SETTLE_CYCLES, default 1, number of clock cycles each 32-bit half is held on the adder before its result is captured; legal range 1..15.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  upstream request carries a valid 64-bit add.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_a  input  64  operand A.
REQ-008 in_b  input  64  operand B.
REQ-009 in_cin  input  1  carry into bit 0.
REQ-010 add_a  output  32  operand A half driven to the external 32-bit ripple-carry adder.
REQ-011 add_b  output  32  operand B half driven to the adder.
REQ-012 add_cin  output  1  carry driven to the adder.
REQ-013 add_sum  input  32  combinational sum returned by the adder.
REQ-014 add_cout  input  1  combinational carry-out returned by the adder.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  downstream accepts the result.
REQ-017 out_sum  output  64  registered 64-bit sum.
REQ-018 out_cout  output  1  carry out of bit 63.
REQ-019 out_ovf  output  1  signed two's-complement overflow of the 64-bit add.

Function
REQ-020 FSM states SHALL be IDLE, LO, HI, DONE; the reset state SHALL be IDLE.
REQ-021 in_ready SHALL be 1 only in IDLE; a handshake occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-022 On handshake: register in_a, in_b, in_cin; clear settle counter; go to LO. in_valid outside IDLE SHALL be ignored.
REQ-023 In LO: add_a=A[31:0], add_b=B[31:0], add_cin=registered cin.
REQ-024 In HI: add_a=A[63:32], add_b=B[63:32], add_cin=captured low-half carry.
REQ-025 In IDLE and DONE: add_a, add_b, add_cin SHALL be driven to 0.
REQ-026 Settle counter: 4 bits, increments each cycle in LO/HI; at the edge where counter==SETTLE_CYCLES-1, capture the result and clear the counter.
REQ-027 LO capture: add_sum into out_sum[31:0], add_cout into the internal low carry; go to HI.
REQ-028 HI capture: add_sum into out_sum[63:32], add_cout into out_cout, out_ovf=(A[63]==B[63])&&(add_sum[31]!=A[63]); go to DONE.
REQ-029 Latency: out_valid SHALL rise exactly 2*SETTLE_CYCLES cycles after the accepting edge.
REQ-030 In DONE, out_valid=1; out_sum, out_cout, out_ovf SHALL be held stable until the edge where out_ready=1, then go to IDLE with out_valid=0.
REQ-031 No bypass: in_ready SHALL be 0 in the DONE cycle where out_ready is sampled; the next request is accepted no earlier than the following cycle.
REQ-032 out_sum, out_cout, out_ovf SHALL keep their last values in IDLE until the next capture overwrites them.
REQ-033 Arithmetic SHALL be modulo 2^64; carry out of bit 31 SHALL feed bit 32 only via add_cin in HI.

Reset
REQ-034 While rst=1, regardless of clk: state=IDLE, counter=0; out_sum, out_cout, out_ovf, out_valid and all operand and carry registers SHALL be 0.
REQ-035 Reset asserted in LO, HI or DONE SHALL abandon the transaction with no output pulse; after deassertion the first handshake SHALL behave as from power-up.

Verification
REQ-036 Reset: assert rst mid-cycle -> immediately out_valid=0, in_ready=1, out_sum=0, add_a=add_b=0.
REQ-037 Cross-half carry, SETTLE_CYCLES=1: in_a=64'h0000_0000_FFFF_FFFF, in_b=1, in_cin=0 -> out_sum=64'h0000_0001_0000_0000, out_cout=0, out_ovf=0, out_valid 2 cycles after accept.
REQ-038 Full ripple: in_a=64'hFFFF_FFFF_FFFF_FFFF, in_b=0, in_cin=1 -> out_sum=0, out_cout=1, out_ovf=0.
REQ-039 Signed overflow: in_a=64'h7FFF_FFFF_FFFF_FFFF, in_b=1, in_cin=0 -> out_sum=64'h8000_0000_0000_0000, out_cout=0, out_ovf=1.
REQ-040 Backpressure and latency, SETTLE_CYCLES=3: hold out_ready=0 for 5 cycles with in_valid=1 and changing in_a -> out_valid rises 6 cycles after accept, outputs stable, in_ready=0, no second request taken until after the out_ready handshake.
REQ-041 Reset in HI: assert rst one cycle into HI -> no out_valid pulse; then 5+7, cin=0 -> out_sum=12.
